// File: rtl/debounce_toggle_pulse.sv
`default_nettype none
// ============================================================================
// Module   : debounce_toggle_pulse
// Brief    : Synchronises and debounces a raw pushbutton and emits one t_pulse
//            per accepted press, plus the debounced level.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_toggle_pulse #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic t_pulse,
  output logic btn_level,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   level_q, level_d;
  logic                   busy_q, busy_d;

  // Metastability chain; only its last stage feeds the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;

    case (state_q)
      S_LOW: begin
        if (btn_sync) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      S_RISE: begin
        if (!btn_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      S_HIGH: begin
        if (!btn_sync) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      S_FALL: begin
        // Releases settle the level but never strobe t_pulse.
        if (btn_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_RISE) || (state_d == S_FALL);
  end

  assign t_pulse   = pulse_q;
  assign btn_level = level_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_toggle_pulse.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_toggle_pulse
// Brief    : Directed self-checking bench for debounce_toggle_pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_toggle_pulse;

  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int LAT  = SYNC + STAB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic t_pulse;
  logic btn_level;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  debounce_toggle_pulse #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .t_pulse  (t_pulse),
    .btn_level(btn_level),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_all_low(input string tag);
    check_eq({tag, "_pulse"}, 32'(t_pulse), 32'd0);
    check_eq({tag, "_level"}, 32'(btn_level), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int npulse;
    logic q;
    int pat [5] = '{1, 0, 1, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_low("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean press
    btn_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_eq($sformatf("clean_pulse_e%0d", k), 32'(t_pulse), 32'(k == LAT));
      check_eq($sformatf("clean_level_e%0d", k), 32'(btn_level), 32'(k >= LAT));
      check_eq($sformatf("clean_busy_e%0d", k), 32'(busy), 32'(k >= 3 && k < LAT));
    end
    idle(12);
    check_eq("clean_release_level", 32'(btn_level), 32'd0);

    // Bouncy press: steady 1 from edge 6, pulse at edge 11
    for (int k = 1; k <= 20; k++) begin
      btn_in = (k <= 5) ? pat[k-1][0] : 1'b1;
      tick();
      check_eq($sformatf("bounce_pulse_e%0d", k), 32'(t_pulse), 32'(k == 11));
      check_eq($sformatf("bounce_level_e%0d", k), 32'(btn_level), 32'(k >= 11));
    end
    idle(12);

    // Glitch of three cycles is rejected
    for (int k = 1; k <= 12; k++) begin
      btn_in = (k <= 3);
      tick();
      check_eq($sformatf("glitch_pulse_e%0d", k), 32'(t_pulse), 32'd0);
      check_eq($sformatf("glitch_level_e%0d", k), 32'(btn_level), 32'd0);
      check_eq($sformatf("glitch_busy_e%0d", k), 32'(busy), 32'(k >= 3 && k <= 5));
    end

    // Long hold, then bouncy release
    npulse = 0;
    btn_in = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (t_pulse) npulse++;
    end
    check_eq("hold_pulses", 32'(npulse), 32'd1);
    check_eq("hold_level", 32'(btn_level), 32'd1);
    for (int r = 1; r <= 15; r++) begin
      btn_in = (r == 2);
      tick();
      check_eq($sformatf("rel_level_e%0d", r), 32'(btn_level), 32'(r < 8));
      check_eq($sformatf("rel_pulse_e%0d", r), 32'(t_pulse), 32'd0);
      check_eq($sformatf("rel_busy_e%0d", r), 32'(busy), 32'(r == 3 || (r >= 5 && r <= 7)));
    end

    // Three presses spaced 12 cycles driving a toggle flop
    npulse = 0;
    q = 1'b0;
    for (int k = 0; k < 40; k++) begin
      btn_in = (k < 36) && ((k % 12) < 6);
      tick();
      if (t_pulse) begin
        npulse++;
        q = ~q;
      end
    end
    check_eq("toggle_pulses", 32'(npulse), 32'd3);
    check_eq("toggle_q", 32'(q), 32'd1);
    idle(12);

    // Reset while qualifying (S_RISE, cnt=2)
    btn_in = 1'b1;
    repeat (4) tick();
    check_eq("rst1_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("rst1_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("rst1_pulse_e%0d", k), 32'(t_pulse), 32'(k == LAT));
      check_eq($sformatf("rst1_level_e%0d", k), 32'(btn_level), 32'(k >= LAT));
    end
    idle(12);

    // Reset during the t_pulse cycle
    btn_in = 1'b1;
    repeat (LAT) tick();
    check_eq("rst2_pre_pulse", 32'(t_pulse), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("rst2_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("rst2_pulse_e%0d", k), 32'(t_pulse), 32'(k == LAT));
      check_eq($sformatf("rst2_level_e%0d", k), 32'(btn_level), 32'(k >= LAT));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
